// File: rtl/aes_spi_master.sv
// -----------------------------------------------------------------------------
// aes_spi_master
//   Host-side SPI master for the AES decryption core's SPI slave port.
//   A transaction shifts {cyphertext, key} out on mosi MSB first while load is
//   high. It then waits for the core's done flag and clocks the 128-bit
//   plaintext back in on miso. sclk is derived from clk by division. Each bit
//   period is CLKDIV cycles low followed by CLKDIV cycles high.
//
// Ports
//   clk         system clock
//   reset       asynchronous active-high reset
//   start       single-cycle request, accepted only when idle
//   key         K-bit decryption key, sampled on accepted start
//   cyphertext  128-bit block, sampled on accepted start
//   plaintext   last received block, held until the next valid
//   valid       one-cycle pulse, plaintext updated
//   error       one-cycle pulse, done never arrived within TIMEOUT cycles
//   busy        high from the cycle after start until the cycle after valid/error
//   sclk        SPI clock, idle low
//   mosi        serial data to the core
//   load        high for the whole shift-in phase
//   done        asynchronous completion flag from the core
//   miso        serial data from the core
// -----------------------------------------------------------------------------
module aes_spi_master #(
  parameter int K       = 128,
  parameter int CLKDIV  = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [K-1:0]   key,
  input  logic [127:0]   cyphertext,
  output logic [127:0]   plaintext,
  output logic           valid,
  output logic           error,
  output logic           busy,
  output logic           sclk,
  output logic           mosi,
  output logic           load,
  input  logic           done,
  input  logic           miso
);

  localparam int N  = K + 128;
  localparam int BW = $clog2(K + 129);
  localparam int HW = $clog2(CLKDIV);
  localparam int WW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] LAST_TX_BIT = BW'(N - 1);
  localparam logic [BW-1:0] LAST_RX_BIT = BW'(127);
  localparam logic [HW-1:0] HALF_MAX    = HW'(CLKDIV - 1);
  localparam logic [WW-1:0] WAIT_MAX    = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT_IN, WAIT_DONE, SHIFT_OUT} state_t;

  state_t          state;
  logic [N-1:0]    tx;        // bits still to send, next bit at the MSB
  logic [127:0]    rx;
  logic [BW-1:0]   bit_cnt;
  logic [HW-1:0]   half_cnt;
  logic [WW-1:0]   wait_cnt;
  logic            done_meta;
  logic            done_sync;
  logic            half_end;

  assign half_end = (half_cnt == HALF_MAX);

  // done comes from another clock domain, so it is only looked at after two flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_meta <= 1'b0;
      done_sync <= 1'b0;
    end else begin
      done_meta <= done;
      done_sync <= done_meta;
    end
  end

  // NOTE: every state element, including the wide tx/rx shift registers, uses
  // non-blocking assignments and is cleared by reset. This keeps plaintext
  // deterministic after an aborted transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      half_cnt  <= '0;
      wait_cnt  <= '0;
      plaintext <= '0;
      valid     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      load      <= 1'b0;
    end else begin
      valid <= 1'b0;
      error <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          sclk <= 1'b0;
          mosi <= 1'b0;
          load <= 1'b0;
          if (start) begin
            // Bit 0 goes straight onto mosi, and tx keeps the remaining bits.
            mosi     <= cyphertext[127];
            tx       <= {cyphertext[126:0], key, 1'b0};
            load     <= 1'b1;
            busy     <= 1'b1;
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT_IN;
          end
        end

        SHIFT_IN: begin
          half_cnt <= half_end ? '0 : half_cnt + 1'b1;
          if (half_end) begin
            if (!sclk) begin
              sclk <= 1'b1;
            end else begin
              // Falling edge: mosi only ever changes here, which gives a full
              // low phase of setup before the next rise.
              sclk <= 1'b0;
              if (bit_cnt == LAST_TX_BIT) begin
                load     <= 1'b0;
                mosi     <= 1'b0;
                wait_cnt <= '0;
                state    <= WAIT_DONE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                mosi    <= tx[N-1];
                tx      <= {tx[N-2:0], 1'b0};
              end
            end
          end
        end

        WAIT_DONE: begin
          // done is tested before the timeout, so done wins a tie.
          if (done_sync) begin
            half_cnt <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT_OUT;
          end else if (wait_cnt == WAIT_MAX) begin
            error <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        SHIFT_OUT: begin
          half_cnt <= half_end ? '0 : half_cnt + 1'b1;
          if (half_end) begin
            if (!sclk) begin
              // Sample at the end of the low phase. The slave changed miso on
              // the previous fall, or it is showing bit 127 since done rose.
              sclk <= 1'b1;
              rx   <= {rx[126:0], miso};
            end else begin
              sclk <= 1'b0;
              if (bit_cnt == LAST_RX_BIT) begin
                plaintext <= rx;
                valid     <= 1'b1;
                state     <= IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// -----------------------------------------------------------------------------
// tb_aes_spi_master
//   Self-checking bench for aes_spi_master (K=128, CLKDIV=2, TIMEOUT=100).
//   A behavioural AES slave captures mosi on sclk rises while load is high. It
//   returns a chosen plaintext MSB first, shifting on sclk falls after done.
//   A passive monitor counts edges, pulses and timing properties.
// -----------------------------------------------------------------------------
module tb_aes_spi_master;

  localparam int K       = 128;
  localparam int CLKDIV  = 2;
  localparam int TIMEOUT = 100;
  localparam int NBITS   = K + 128;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [K-1:0]   key = '0;
  logic [127:0]   cyphertext = '0;
  logic [127:0]   plaintext;
  logic           valid, error, busy, sclk, mosi, load;
  logic           done = 1'b0;
  logic           miso;

  aes_spi_master #(.K(K), .CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .cyphertext (cyphertext),
    .plaintext  (plaintext),
    .valid      (valid),
    .error      (error),
    .busy       (busy),
    .sclk       (sclk),
    .mosi       (mosi),
    .load       (load),
    .done       (done),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural slave: returns plaintext MSB first -----------
  logic [127:0] slave_sh = '0;
  assign miso = slave_sh[127];
  always @(negedge sclk) if (done && !load) slave_sh = {slave_sh[126:0], 1'b0};

  // ---------------- passive monitor, sampled on the falling clk edge ---------
  int           rise_load = 0, rise_free = 0, bad_high = 0, mosi_bad = 0;
  int           valid_cnt = 0, error_cnt = 0, busy_falls = 0, high_len = 0;
  logic         prev_sclk = 1'b0, prev_busy = 1'b0, rise_mosi = 1'b0;
  logic [NBITS-1:0] mosi_cap = '0;

  always @(negedge clk) begin
    if (sclk && !prev_sclk) begin
      if (load) begin
        rise_load++;
        mosi_cap = {mosi_cap[NBITS-2:0], mosi};
      end else begin
        rise_free++;
      end
      high_len  = 1;
      rise_mosi = mosi;
    end else if (sclk) begin
      high_len++;
      if (mosi !== rise_mosi) mosi_bad++;
    end else if (prev_sclk && high_len != CLKDIV) begin
      bad_high++;
    end
    if (valid) valid_cnt++;
    if (error) error_cnt++;
    if (prev_busy && !busy) busy_falls++;
    prev_sclk = sclk;
    prev_busy = busy;
  end

  // ---------------- checking ---------------------------------------------------
  int checks = 0, failures = 0;
  logic [127:0] exp_pt = '0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One transaction. done_dly < 0 means done is never raised (timeout case).
  // poke pulses start while the plaintext is being clocked back.
  task automatic run_txn(input logic [127:0] ct, input logic [K-1:0] k,
                         input logic [127:0] pt, input int done_dly, input bit poke);
    int r0l, r0f, bh0, mb0, v0, e0, bf0, n;
    r0l = rise_load; r0f = rise_free; bh0 = bad_high; mb0 = mosi_bad;
    v0  = valid_cnt; e0  = error_cnt; bf0 = busy_falls;

    cyphertext = ct;
    key        = k;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    check("load_after_start", 256'(load), 256'(1));
    check("busy_after_start", 256'(busy), 256'(1));

    n = 0;
    while (load === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check("load_cycles", 256'(n), 256'(NBITS * 2 * CLKDIV));
    check("rises_with_load", 256'(rise_load - r0l), 256'(NBITS));
    check("mosi_stream", 256'(mosi_cap), 256'({ct, k}));

    if (done_dly >= 0) begin
      repeat (done_dly) @(negedge clk);
      slave_sh = pt;
      done     = 1'b1;
      if (poke) begin
        repeat (12) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      n = 0;
      while (valid !== 1'b1 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      check("valid_seen", 256'(valid), 256'(1));
      check("plaintext", 256'(plaintext), 256'(pt));
      check("busy_in_valid", 256'(busy), 256'(1));
      exp_pt = pt;
      @(negedge clk);
      check("valid_one_cycle", 256'(valid), 256'(0));
      check("busy_after_valid", 256'(busy), 256'(0));
      done = 1'b0;
      repeat (40) @(negedge clk);
      check("rises_without_load", 256'(rise_free - r0f), 256'(128));
      check("valid_count", 256'(valid_cnt - v0), 256'(1));
      check("error_count", 256'(error_cnt - e0), 256'(0));
    end else begin
      n = 0;
      while (error !== 1'b1 && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check("timeout_cycles", 256'(n), 256'(TIMEOUT));
      check("error_seen", 256'(error), 256'(1));
      check("valid_on_timeout", 256'(valid), 256'(0));
      check("plaintext_kept", 256'(plaintext), 256'(exp_pt));
      @(negedge clk);
      check("error_one_cycle", 256'(error), 256'(0));
      check("busy_after_error", 256'(busy), 256'(0));
      repeat (20) @(negedge clk);
      check("rises_without_load", 256'(rise_free - r0f), 256'(0));
      check("valid_count", 256'(valid_cnt - v0), 256'(0));
      check("error_count", 256'(error_cnt - e0), 256'(1));
    end
    check("high_phase_len", 256'(bad_high - bh0), 256'(0));
    check("mosi_stable_high", 256'(mosi_bad - mb0), 256'(0));
    check("busy_falls", 256'(busy_falls - bf0), 256'(1));
    check("idle_busy", 256'(busy), 256'(0));
  endtask

  // ---------------- stimulus ---------------------------------------------------
  initial begin
    logic [127:0] ct_v, pt_v;
    logic [K-1:0] key_v;
    int r0, n;

    repeat (3) @(negedge clk);
    check("rst_sclk", 256'(sclk), 256'(0));
    check("rst_mosi", 256'(mosi), 256'(0));
    check("rst_load", 256'(load), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_valid", 256'(valid), 256'(0));
    check("rst_error", 256'(error), 256'(0));
    check("rst_plaintext", 256'(plaintext), 256'(0));
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // FIPS-197 AES-128 vector, done 50 cycles after load falls.
    run_txn(128'h69c4e0d86a7b0430d8cdb78070b4c55a,
            128'h000102030405060708090a0b0c0d0e0f,
            128'h00112233445566778899aabbccddeeff, 50, 1'b0);

    // Bit order: only the first and last bits on the wire are set.
    ct_v  = '0; ct_v[127] = 1'b1;
    key_v = '0; key_v[0]  = 1'b1;
    run_txn(ct_v, key_v, rand128(), 10, 1'b0);
    check("first_bit", 256'(mosi_cap[NBITS-1]), 256'(1));
    check("middle_bits", 256'(mosi_cap[NBITS-2:1]), 256'(0));
    check("last_bit", 256'(mosi_cap[0]), 256'(1));

    // Random transactions with random done latency.
    for (int i = 0; i < 3; i++) begin
      run_txn(rand128(), rand128(), rand128(), int'($urandom_range(60, 0)), 1'b0);
    end

    // A start pulsed while the plaintext is being clocked back must be ignored.
    run_txn(rand128(), rand128(), rand128(), int'($urandom_range(30, 0)), 1'b1);

    // done never arrives.
    run_txn(rand128(), rand128(), 128'h0, -1, 1'b0);

    // Reset in the middle of the shift-in phase.
    r0 = rise_load;
    cyphertext = rand128();
    key        = rand128();
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    n = 0;
    while (rise_load - r0 < 40 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_bit40", 256'(rise_load - r0 >= 40), 256'(1));
    reset = 1'b1;
    #1;
    check("midrst_sclk", 256'(sclk), 256'(0));
    check("midrst_load", 256'(load), 256'(0));
    check("midrst_busy", 256'(busy), 256'(0));
    check("midrst_valid", 256'(valid), 256'(0));
    check("midrst_error", 256'(error), 256'(0));
    @(negedge clk);
    reset  = 1'b0;
    exp_pt = '0;
    repeat (3) @(negedge clk);
    check("midrst_plaintext", 256'(plaintext), 256'(0));
    run_txn(rand128(), rand128(), rand128(), int'($urandom_range(60, 0)), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
